// File: rtl/parity_serializer_pkg.sv
// Shared types and helpers for the parity-frame transmitter.
//   parity_state_t : FSM state encoding (idle, payload shift, parity bit, idle gap)
//   PARITY_EVEN/ODD: values for the ODD parameter of parity_serializer
//   parity_of()    : reference parity of a word (reduction XOR, optionally inverted)
package parity_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_GAP    = 2'd3
  } parity_state_t;

  localparam int PARITY_EVEN = 0;
  localparam int PARITY_ODD  = 1;

  // Words narrower than 32 bits are zero-extended, which leaves the XOR unchanged.
  function automatic logic parity_of(input logic [31:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/parity_serializer.sv
// Serial parity-frame transmitter.
// Accepts a WIDTH-bit word over a valid/ready handshake and sends it on `data`
// LSB first, one bit per clock, followed by a parity bit and GAP idle cycles.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : in_word is valid
//   in_word    : payload to transmit, sampled only on the accepting edge
//   in_ready   : a word is taken at the next edge when in_valid is high
//   data       : registered serial line, 0 when idle or in the gap
//   busy       : a frame or its trailing gap is on the line
//   frame_done : high during the parity-bit cycle
module parity_serializer
  import parity_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int ODD   = PARITY_EVEN,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_word,
  output logic             in_ready,
  output logic             data,
  output logic             busy,
  output logic             frame_done
);

  localparam int   CW      = $clog2(WIDTH + 1);
  localparam logic ODD_BIT = (ODD != 0);

  parity_state_t    state;
  logic [WIDTH-1:0] shreg;
  logic             acc;
  logic [CW-1:0]    cnt;
  logic             gap_last;
  logic             accept;

  // The gap counter only exists when there is a gap to time.
  if (GAP > 0) begin : g_gap
    localparam int GW = $clog2(GAP + 1);
    logic [GW-1:0] gcnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        gcnt <= '0;
      end else if (state == ST_PARITY) begin
        gcnt <= GW'(1);
      end else if (state == ST_GAP) begin
        gcnt <= gap_last ? '0 : gcnt + 1'b1;
      end
    end

    assign gap_last = (gcnt == GW'(GAP));
  end else begin : g_no_gap
    assign gap_last = 1'b1;
  end

  // Ready on the final cycle of a frame as well as in idle, so the next
  // frame's bit 0 follows the parity/last gap bit without a bubble.
  assign in_ready = (state == ST_IDLE) ||
                    (state == ST_PARITY && GAP == 0) ||
                    (state == ST_GAP && gap_last);
  assign accept   = in_valid && in_ready;

  // data shows the bit of the current state: on acceptance bit 0 goes out
  // immediately, the shift register keeps the remaining bits and the
  // accumulator already includes bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      acc        <= 1'b0;
      cnt        <= '0;
      data       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          data <= 1'b0;
        end
        ST_SHIFT: begin
          if (cnt == CW'(WIDTH)) begin
            state      <= ST_PARITY;
            data       <= acc;
            frame_done <= 1'b1;
            cnt        <= '0;
          end else begin
            data  <= shreg[0];
            acc   <= acc ^ shreg[0];
            shreg <= shreg >> 1;
            cnt   <= cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          frame_done <= 1'b0;
          data       <= 1'b0;
          if (GAP > 0) begin
            state <= ST_GAP;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_GAP: begin
          data <= 1'b0;
          if (gap_last) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      // A new word overrides whatever the ending state would have done.
      if (accept) begin
        state      <= ST_SHIFT;
        shreg      <= in_word >> 1;
        data       <= in_word[0];
        acc        <= ODD_BIT ^ in_word[0];
        cnt        <= CW'(1);
        busy       <= 1'b1;
        frame_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_parity_serializer.sv
// Bench for parity_serializer: two instances (even/no gap, odd/gap of 2)
// each with a randomized driver, a scoreboard of accepted words and a
// monitor that rebuilds frames from the serial line.
module tb_parity_serializer;

  localparam int W      = 5;
  localparam int NRAND  = 60;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit done [2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int OD = g;
    localparam int GP = 2 * g;

    typedef struct {
      logic [W-1:0] word;
      int           due;
    } exp_t;

    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_word = '0;
    logic         in_ready, data, busy, frame_done;

    exp_t q[$];
    bit   hist[$];
    int   cyc = 0;
    int   sd = 1000;
    bit   active = 1'b0;

    parity_serializer #(.WIDTH(W), .ODD(OD), .GAP(GP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_word   (in_word),
      .in_ready  (in_ready),
      .data      (data),
      .busy      (busy),
      .frame_done(frame_done)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: expectations come from the queue of accepted words and the
    // frame timing rules (bit 0 one cycle after acceptance, parity W cycles later).
    initial begin
      forever begin
        @(negedge clk);
        if (active && rst_n) begin
          bit       fd_exp, busy_exp, rdy_exp;
          logic [W-1:0] got;
          exp_t     e;
          hist.push_back(data);
          if (hist.size() > 32) void'(hist.pop_front());
          if (frame_done) sd = 0;
          else sd = sd + 1;
          fd_exp   = (q.size() > 0) && (q[0].due == cyc);
          busy_exp = ((q.size() > 0) && (cyc >= q[0].due - W)) ||
                     (sd >= 1 && sd <= GP) || fd_exp;
          rdy_exp  = !busy_exp || (fd_exp && GP == 0) || (GP > 0 && sd == GP);
          chk($sformatf("dut%0d frame_done", g), frame_done, fd_exp);
          chk($sformatf("dut%0d busy", g), busy, busy_exp);
          chk($sformatf("dut%0d in_ready", g), in_ready, rdy_exp);
          if (sd >= 1 && sd <= GP)
            chk($sformatf("dut%0d gap_data", g), data, 1'b0);
          if (!busy_exp)
            chk($sformatf("dut%0d idle_data", g), data, 1'b0);
          if (fd_exp) begin
            e = q.pop_front();
            for (int i = 0; i < W; i++) got[i] = hist[hist.size() - 1 - W + i];
            chk($sformatf("dut%0d payload", g), got, e.word);
            chk($sformatf("dut%0d parity w=%0h", g, e.word), data,
                ($countones(e.word) % 2) ^ OD);
          end
        end
      end
    end

    // Driver: the source holds a word while it is not taken; with valid low
    // in_word is scrambled every cycle to show frames in flight are immune.
    initial begin
      logic [W-1:0] dir [4];
      int  idx;
      bit  pend;
      exp_t e;
      dir[0] = 5'b10110; dir[1] = 5'b00000; dir[2] = 5'b11111; dir[3] = 5'b00001;

      @(negedge clk);
      chk($sformatf("dut%0d rst data", g), data, 1'b0);
      chk($sformatf("dut%0d rst busy", g), busy, 1'b0);
      chk($sformatf("dut%0d rst frame_done", g), frame_done, 1'b0);
      chk($sformatf("dut%0d rst in_ready", g), in_ready, 1'b1);
      rst_n  = 1'b1;
      active = 1'b1;

      idx  = 0;
      pend = 1'b0;
      while (idx < 4 + NRAND) begin
        @(negedge clk);
        if (!pend) begin
          if (idx < 4 || $urandom_range(0, 9) < 7) begin
            in_valid = 1'b1;
            in_word  = (idx < 4) ? dir[idx] : W'($urandom);
            pend     = 1'b1;
          end else begin
            in_valid = 1'b0;
            in_word  = W'($urandom);
          end
        end
        if (pend && in_ready) begin
          e.word = in_word;
          e.due  = cyc + 1 + W;
          q.push_back(e);
          idx++;
          pend = 1'b0;
        end
      end
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 300 && q.size() > 0; i++) begin
        @(negedge clk);
        in_word = W'($urandom);
      end
      chk($sformatf("dut%0d drain", g), q.size(), 0);
      repeat (GP + 2) @(negedge clk);

      // Reset in the middle of a frame, while bit 2 is on the line.
      active   = 1'b0;
      in_valid = 1'b1;
      in_word  = 5'b11001;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("dut%0d prerst busy", g), busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk($sformatf("dut%0d arst data", g), data, 1'b0);
      chk($sformatf("dut%0d arst busy", g), busy, 1'b0);
      chk($sformatf("dut%0d arst frame_done", g), frame_done, 1'b0);
      chk($sformatf("dut%0d arst in_ready", g), in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      hist.delete();
      sd     = 1000;
      active = 1'b1;
      in_valid = 1'b1;
      in_word  = 5'b00111;
      chk($sformatf("dut%0d postrst in_ready", g), in_ready, 1'b1);
      if (in_ready) begin
        e.word = in_word;
        e.due  = cyc + 1 + W;
        q.push_back(e);
      end
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
      chk($sformatf("dut%0d postrst drain", g), q.size(), 0);
      repeat (GP + 2) @(negedge clk);
      done[g] = 1'b1;
    end
  end

  initial begin
    fork
      wait (done[0] && done[1]);
      begin
        #400000;
        failures++;
        $display("FAIL timeout done0=%0d done1=%0d", done[0], done[1]);
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
